// File: rtl/up_mem_ctrl.sv
// Memory controller: multi-phase address latch, wait-state sequencer and
// internal word-addressed RAM with optional post-increment addressing.
module up_mem_ctrl #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              ale,
   input  logic [DATA_W-1:0] din,
   input  logic              re,
   input  logic              we,
   input  logic              inc,
   output logic [DATA_W-1:0] dout,
   output logic              ready,
   output logic              busy,
   output logic [ADDR_W-1:0] addr
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [3:0]        cnt;
   logic [3:0]        next_cnt;
   logic              req;
   logic              op_wr;
   logic              inc_f;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] acc_addr;
   logic              eff_wr;
   logic [ADDR_W-1:0] eff_addr;
   logic [DATA_W-1:0] eff_wdata;
   logic              commit;
   logic              in_range;
   logic [IDX_W-1:0]  idx;

   logic [DATA_W-1:0] mem [DEPTH];

   // MSB-phase-first shift of one data-bus word into the address latch
   function automatic logic [ADDR_W-1:0] shift_in(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] d);
      return ADDR_W'({a, d});
   endfunction

   // Next-state and wait counter sequencing
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      req        = 1'b0;
      case (state)
         IDLE: begin
            req = re | we;
            if (req) begin
               if (WAIT_STATES == 0) begin
                  next_state = DONE;
               end else begin
                  next_state = WAIT;
                  next_cnt   = 4'(WAIT_STATES);
               end
            end else begin
               next_state = IDLE;
            end
         end
         WAIT: begin
            if (cnt == 4'd1) begin
               next_state = DONE;
            end else begin
               next_state = WAIT;
               next_cnt   = cnt - 4'd1;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // With zero wait states the RAM is touched on the request edge itself,
   // so the live inputs must be used instead of the captured copies.
   always_comb begin
      if (req) begin
         eff_wr    = we;
         eff_addr  = addr;
         eff_wdata = din;
      end else begin
         eff_wr    = op_wr;
         eff_addr  = acc_addr;
         eff_wdata = wdata;
      end
      commit   = (next_state == DONE) && (state != DONE);
      in_range = ({1'b0, eff_addr} < (ADDR_W+1)'(DEPTH));
      idx      = eff_addr[IDX_W-1:0];
   end

   // Sequencer state, captured access, address latch and read data
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         ready    <= 1'b0;
         busy     <= 1'b0;
         op_wr    <= 1'b0;
         inc_f    <= 1'b0;
         wdata    <= '0;
         acc_addr <= '0;
         dout     <= '0;
         addr     <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         ready <= (next_state == DONE);
         busy  <= (next_state != IDLE);
         if (req) begin
            op_wr    <= we;
            wdata    <= din;
            inc_f    <= inc;
            acc_addr <= addr;
         end
         if (commit && !eff_wr) begin
            dout <= in_range ? mem[idx] : '0;
         end
         if (state == DONE && inc_f) begin
            addr <= addr + ADDR_W'(1);
         end else if (state == IDLE && !req && ale) begin
            addr <= shift_in(addr, din);
         end
      end
   end

   // RAM write port; contents deliberately not reset
   always_ff @(posedge clk) begin
      if (commit && eff_wr && in_range && !Rst) begin
         mem[idx] <= eff_wdata;
      end
   end

endmodule
